aurora_link_ctrl: RTL and testbench

- Link bring-up and recovery controller for the dual-channel Aurora 8b10b module; runs on the 100 MHz free-running clock.
- Drives each channel's reset and loopback, monitors lane_up/channel_up/hard_err, and re-initialises a channel on timeout or link loss.
- Gives up after a bounded number of retries and reports per-channel status to system logic.
- Two identical independent per-channel FSMs, c0 and c1.

---
 rtl/aurora_link_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_aurora_link_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_ctrl.sv
// Bring-up and recovery controller for a dual-channel Aurora 8b10b link.
// Each channel runs an independent reset/wait/up/fail FSM fed by synchronised status.
`timescale 1ns/1ps
module aurora_link_ctrl #(
  parameter int unsigned RST_HOLD_CYC   = 128,
  parameter int unsigned UP_TIMEOUT_CYC = 1000000,
  parameter int unsigned STABLE_CYC     = 64,
  parameter int unsigned RETRY_MAX      = 15
) (
  input  logic       i_clk_100M,
  input  logic       i_rst,
  input  logic [1:0] i_enable,
  input  logic [1:0] i_retry,
  input  logic [2:0] i_c0_loopback_cfg,
  input  logic       i_c0_lane_up,
  input  logic       i_c0_channel_up,
  input  logic       i_c0_hard_err,
  input  logic [2:0] i_c1_loopback_cfg,
  input  logic       i_c1_lane_up,
  input  logic       i_c1_channel_up,
  input  logic       i_c1_hard_err,
  output logic       o_c0_reset,
  output logic [2:0] o_c0_loopback,
  output logic [2:0] o_c0_state,
  output logic       o_c0_link_ok,
  output logic       o_c0_fail,
  output logic [7:0] o_c0_retry_cnt,
  output logic [7:0] o_c0_drop_cnt,
  output logic       o_c1_reset,
  output logic [2:0] o_c1_loopback,
  output logic [2:0] o_c1_state,
  output logic       o_c1_link_ok,
  output logic       o_c1_fail,
  output logic [7:0] o_c1_retry_cnt,
  output logic [7:0] o_c1_drop_cnt,
  output logic       o_all_up
);

  localparam int unsigned HoldW   = $clog2(RST_HOLD_CYC) + 1;
  localparam int unsigned StableW = $clog2(STABLE_CYC) + 1;
  localparam int unsigned TmoW    = $clog2(UP_TIMEOUT_CYC) + 1;

  localparam logic [HoldW-1:0]   HoldLast   = HoldW'(RST_HOLD_CYC - 1);
  localparam logic [StableW-1:0] StableLast = StableW'(STABLE_CYC - 1);
  localparam logic [TmoW-1:0]    TmoLast    = TmoW'(UP_TIMEOUT_CYC - 1);
  localparam logic [7:0]         RetryLimit = 8'(RETRY_MAX);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReset  = 3'd1,
    StWaitUp = 3'd2,
    StUp     = 3'd3,
    StFail   = 3'd4
  } state_e;

  logic [1:0]  lane_raw, chan_raw, herr_raw;
  logic [5:0]  cfg_all;
  logic [1:0]  reset_all, link_ok_all, fail_all;
  logic [5:0]  state_all, loopback_all;
  logic [15:0] retry_all, drop_all;
  logic        all_up_q;

  assign lane_raw = {i_c1_lane_up, i_c0_lane_up};
  assign chan_raw = {i_c1_channel_up, i_c0_channel_up};
  assign herr_raw = {i_c1_hard_err, i_c0_hard_err};
  assign cfg_all  = {i_c1_loopback_cfg, i_c0_loopback_cfg};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [1:0]         lane_sync, chan_sync, herr_sync;
    logic               up, herr, lb_change;
    logic [2:0]         cfg;
    state_e             state_q;
    logic               reset_q, link_ok_q, fail_q;
    logic [2:0]         loopback_q;
    logic [7:0]         retry_q, drop_q, retry_inc;
    logic [HoldW-1:0]   hold_q;
    logic [StableW-1:0] stable_q;
    logic [TmoW-1:0]    tmo_q;

    assign cfg       = cfg_all[3*g +: 3];
    assign up        = lane_sync[1] & chan_sync[1];
    assign herr      = herr_sync[1];
    assign lb_change = (cfg != loopback_q);
    assign retry_inc = retry_q + 8'd1;

    always_ff @(posedge i_clk_100M) begin
      if (i_rst) begin
        lane_sync  <= '0;
        chan_sync  <= '0;
        herr_sync  <= '0;
        state_q    <= StIdle;
        reset_q    <= 1'b1;
        link_ok_q  <= 1'b0;
        fail_q     <= 1'b0;
        loopback_q <= '0;
        retry_q    <= '0;
        drop_q     <= '0;
        hold_q     <= '0;
        stable_q   <= '0;
        tmo_q      <= '0;
      end else begin
        lane_sync <= {lane_sync[0], lane_raw[g]};
        chan_sync <= {chan_sync[0], chan_raw[g]};
        herr_sync <= {herr_sync[0], herr_raw[g]};

        if (!i_enable[g]) begin
          state_q   <= StIdle;
          reset_q   <= 1'b1;
          link_ok_q <= 1'b0;
          fail_q    <= 1'b0;
          retry_q   <= '0;
        end else begin
          unique case (state_q)
            StIdle: begin
              state_q    <= StReset;
              reset_q    <= 1'b1;
              loopback_q <= cfg;
              retry_q    <= '0;
              hold_q     <= '0;
              stable_q   <= '0;
              tmo_q      <= '0;
            end
            StReset: begin
              // Reset deasserts on the same edge that enters WAIT_UP.
              if (hold_q == HoldLast) begin
                state_q <= StWaitUp;
                reset_q <= 1'b0;
              end else begin
                hold_q <= hold_q + HoldW'(1);
              end
            end
            StWaitUp: begin
              if (lb_change) begin
                state_q    <= StReset;
                reset_q    <= 1'b1;
                loopback_q <= cfg;
                hold_q     <= '0;
                stable_q   <= '0;
                tmo_q      <= '0;
              end else if (up && stable_q == StableLast) begin
                // Stable completion beats a coincident timeout.
                state_q   <= StUp;
                link_ok_q <= 1'b1;
                retry_q   <= '0;
              end else if (tmo_q == TmoLast) begin
                retry_q  <= retry_inc;
                reset_q  <= 1'b1;
                hold_q   <= '0;
                stable_q <= '0;
                tmo_q    <= '0;
                if (retry_inc == RetryLimit) begin
                  state_q <= StFail;
                  fail_q  <= 1'b1;
                end else begin
                  state_q <= StReset;
                end
              end else begin
                tmo_q    <= tmo_q + TmoW'(1);
                stable_q <= up ? stable_q + StableW'(1) : '0;
              end
            end
            StUp: begin
              if (lb_change) begin
                state_q    <= StReset;
                reset_q    <= 1'b1;
                link_ok_q  <= 1'b0;
                loopback_q <= cfg;
                hold_q     <= '0;
                stable_q   <= '0;
                tmo_q      <= '0;
              end else if (!up || herr) begin
                state_q   <= StReset;
                reset_q   <= 1'b1;
                link_ok_q <= 1'b0;
                hold_q    <= '0;
                stable_q  <= '0;
                tmo_q     <= '0;
                if (drop_q != 8'hff) drop_q <= drop_q + 8'd1;
              end
            end
            StFail: begin
              if (i_retry[g]) begin
                state_q  <= StReset;
                fail_q   <= 1'b0;
                retry_q  <= '0;
                hold_q   <= '0;
                stable_q <= '0;
                tmo_q    <= '0;
              end
            end
            default: begin
              state_q <= StIdle;
              reset_q <= 1'b1;
            end
          endcase
        end
      end
    end

    assign reset_all[g]           = reset_q;
    assign link_ok_all[g]         = link_ok_q;
    assign fail_all[g]            = fail_q;
    assign state_all[3*g +: 3]    = state_q;
    assign loopback_all[3*g +: 3] = loopback_q;
    assign retry_all[8*g +: 8]    = retry_q;
    assign drop_all[8*g +: 8]     = drop_q;
  end

  // Disabled channels do not hold all_up low; no enabled channel means not up.
  always_ff @(posedge i_clk_100M) begin
    if (i_rst) begin
      all_up_q <= 1'b0;
    end else begin
      all_up_q <= (i_enable != 2'b00) && ((link_ok_all | ~i_enable) == 2'b11);
    end
  end

  assign o_c0_reset     = reset_all[0];
  assign o_c0_loopback  = loopback_all[2:0];
  assign o_c0_state     = state_all[2:0];
  assign o_c0_link_ok   = link_ok_all[0];
  assign o_c0_fail      = fail_all[0];
  assign o_c0_retry_cnt = retry_all[7:0];
  assign o_c0_drop_cnt  = drop_all[7:0];
  assign o_c1_reset     = reset_all[1];
  assign o_c1_loopback  = loopback_all[5:3];
  assign o_c1_state     = state_all[5:3];
  assign o_c1_link_ok   = link_ok_all[1];
  assign o_c1_fail      = fail_all[1];
  assign o_c1_retry_cnt = retry_all[15:8];
  assign o_c1_drop_cnt  = drop_all[15:8];
  assign o_all_up       = all_up_q;

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Directed bench for aurora_link_ctrl: expectations are queued as stimulus is applied and
// popped when the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_aurora_link_ctrl;

  localparam int unsigned RST_HOLD  = 16;
  localparam int unsigned TMO       = 200;
  localparam int unsigned STABLE    = 8;
  localparam int unsigned RETRY_MAX = 3;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_enable, i_retry;
  logic [2:0] i_c0_loopback_cfg, i_c1_loopback_cfg;
  logic       i_c0_lane_up, i_c0_channel_up, i_c0_hard_err;
  logic       i_c1_lane_up, i_c1_channel_up, i_c1_hard_err;
  logic       o_c0_reset, o_c0_link_ok, o_c0_fail;
  logic       o_c1_reset, o_c1_link_ok, o_c1_fail;
  logic [2:0] o_c0_loopback, o_c0_state, o_c1_loopback, o_c1_state;
  logic [7:0] o_c0_retry_cnt, o_c0_drop_cnt, o_c1_retry_cnt, o_c1_drop_cnt;
  logic       o_all_up;

  aurora_link_ctrl #(
    .RST_HOLD_CYC  (RST_HOLD),
    .UP_TIMEOUT_CYC(TMO),
    .STABLE_CYC    (STABLE),
    .RETRY_MAX     (RETRY_MAX)
  ) dut (
    .i_clk_100M       (clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_retry          (i_retry),
    .i_c0_loopback_cfg(i_c0_loopback_cfg),
    .i_c0_lane_up     (i_c0_lane_up),
    .i_c0_channel_up  (i_c0_channel_up),
    .i_c0_hard_err    (i_c0_hard_err),
    .i_c1_loopback_cfg(i_c1_loopback_cfg),
    .i_c1_lane_up     (i_c1_lane_up),
    .i_c1_channel_up  (i_c1_channel_up),
    .i_c1_hard_err    (i_c1_hard_err),
    .o_c0_reset       (o_c0_reset),
    .o_c0_loopback    (o_c0_loopback),
    .o_c0_state       (o_c0_state),
    .o_c0_link_ok     (o_c0_link_ok),
    .o_c0_fail        (o_c0_fail),
    .o_c0_retry_cnt   (o_c0_retry_cnt),
    .o_c0_drop_cnt    (o_c0_drop_cnt),
    .o_c1_reset       (o_c1_reset),
    .o_c1_loopback    (o_c1_loopback),
    .o_c1_state       (o_c1_state),
    .o_c1_link_ok     (o_c1_link_ok),
    .o_c1_fail        (o_c1_fail),
    .o_c1_retry_cnt   (o_c1_retry_cnt),
    .o_c1_drop_cnt    (o_c1_drop_cnt),
    .o_all_up         (o_all_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   glitch = 1'b0;
  int   gcnt = 0;
  bit   c1_saw_up = 1'b0;
  int   n;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d required a queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_c1_state == 3'd3) c1_saw_up = 1'b1;
    if (glitch) begin
      i_c1_lane_up = ((gcnt % 8) != 7);
      gcnt++;
    end
  endtask

  task automatic wait_c0(input logic [2:0] s, input int bound);
    for (int k = 0; k < bound && o_c0_state != s; k++) tick();
  endtask

  task automatic wait_c1(input logic [2:0] s, input int bound);
    for (int k = 0; k < bound && o_c1_state != s; k++) tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_enable = 2'b00;
    i_retry = 2'b00;
    i_c0_loopback_cfg = 3'd0;
    i_c1_loopback_cfg = 3'd0;
    {i_c0_lane_up, i_c0_channel_up, i_c0_hard_err} = 3'b000;
    {i_c1_lane_up, i_c1_channel_up, i_c1_hard_err} = 3'b000;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();

    // Reset values
    expect_val("rst_c0_state", 0);    check(o_c0_state);
    expect_val("rst_c0_reset", 1);    check(o_c0_reset);
    expect_val("rst_c0_loopback", 0); check(o_c0_loopback);
    expect_val("rst_c0_link_ok", 0);  check(o_c0_link_ok);
    expect_val("rst_c1_fail", 0);     check(o_c1_fail);
    expect_val("rst_c0_drop", 0);     check(o_c0_drop_cnt);
    expect_val("rst_all_up", 0);      check(o_all_up);

    // 1. Normal bring-up on c0
    cyc = 0;
    i_enable = 2'b01;
    expect_val("t1_reset_fall_cycle", 1 + RST_HOLD);
    for (int k = 0; k < 100 && o_c0_reset; k++) tick();
    check(cyc);
    expect_val("t1_state_wait_up", 2); check(o_c0_state);
    while (cyc < 30) tick();
    i_c0_lane_up = 1'b1;
    i_c0_channel_up = 1'b1;
    expect_val("t1_up_cycle", 30 + 2 + STABLE);
    wait_c0(3'd3, 100);
    check(cyc);
    expect_val("t1_link_ok", 1);        check(o_c0_link_ok);
    expect_val("t1_all_up_lag", 0);     check(o_all_up);
    tick();
    expect_val("t1_all_up", 1);         check(o_all_up);
    expect_val("t1_c1_idle", 0);        check(o_c1_state);
    expect_val("t1_c1_reset", 1);       check(o_c1_reset);

    // 2. Timeouts to FAIL on c1
    i_enable = 2'b11;
    for (int a = 1; a <= int'(RETRY_MAX); a++) begin
      wait_c1(3'd2, 40);
      n = 0;
      while (o_c1_state == 3'd2 && n < 300) begin
        tick();
        n++;
      end
      expect_val("t2_wait_dwell", TMO);                  check(n);
      expect_val("t2_retry_cnt", a);                     check(o_c1_retry_cnt);
      expect_val("t2_state", (a == int'(RETRY_MAX)) ? 4 : 1); check(o_c1_state);
    end
    expect_val("t2_fail_flag", 1);    check(o_c1_fail);
    expect_val("t2_fail_reset", 1);   check(o_c1_reset);
    expect_val("t2_c0_still_up", 3);  check(o_c0_state);
    expect_val("t2_all_up_low", 0);   check(o_all_up);
    repeat (5) tick();
    expect_val("t2_fail_hold", 4);    check(o_c1_state);
    expect_val("t2_retry_hold", RETRY_MAX); check(o_c1_retry_cnt);
    i_retry = 2'b10;
    tick();
    i_retry = 2'b00;
    expect_val("t2_retry_state", 1);  check(o_c1_state);
    expect_val("t2_retry_clear", 0);  check(o_c1_retry_cnt);
    expect_val("t2_fail_clear", 0);   check(o_c1_fail);
    i_enable = 2'b01;
    tick();
    expect_val("t2_c1_idle", 0);      check(o_c1_state);
    expect_val("t2_all_up_back", 1);  check(o_all_up);

    // 3. Link drop on hard_err
    i_c0_hard_err = 1'b1;
    tick();
    i_c0_hard_err = 1'b0;
    tick();
    expect_val("t3_still_up", 3);     check(o_c0_state);
    tick();
    expect_val("t3_state_reset", 1);  check(o_c0_state);
    expect_val("t3_drop_cnt", 1);     check(o_c0_drop_cnt);
    expect_val("t3_retry_cnt", 0);    check(o_c0_retry_cnt);
    expect_val("t3_link_ok", 0);      check(o_c0_link_ok);
    tick();
    expect_val("t3_all_up", 0);       check(o_all_up);
    wait_c0(3'd3, 100);
    expect_val("t3_relink", 3);       check(o_c0_state);

    // 4. Loopback change while up
    i_c0_loopback_cfg = 3'd2;
    tick();
    expect_val("t4_state_reset", 1);  check(o_c0_state);
    expect_val("t4_loopback", 2);     check(o_c0_loopback);
    expect_val("t4_drop_kept", 1);    check(o_c0_drop_cnt);
    expect_val("t4_retry_kept", 0);   check(o_c0_retry_cnt);
    wait_c0(3'd3, 100);
    expect_val("t4_relink", 3);       check(o_c0_state);

    // 5. Glitchy up on c1: 7 high, 1 low
    i_c1_channel_up = 1'b1;
    gcnt = 0;
    glitch = 1'b1;
    c1_saw_up = 1'b0;
    i_enable = 2'b11;
    wait_c1(3'd2, 40);
    n = 0;
    while (o_c1_state == 3'd2 && n < 300) begin
      tick();
      n++;
    end
    glitch = 1'b0;
    i_c1_lane_up = 1'b0;
    i_c1_channel_up = 1'b0;
    expect_val("t5_wait_dwell", TMO); check(n);
    expect_val("t5_never_up", 0);     check(c1_saw_up);
    expect_val("t5_retry_cnt", 1);    check(o_c1_retry_cnt);
    expect_val("t5_state", 1);        check(o_c1_state);
    expect_val("t5_c0_drop", 1);      check(o_c0_drop_cnt);

    // 6a. c0 loses link, times out once, then is disabled during WAIT_UP
    i_c0_lane_up = 1'b0;
    wait_c0(3'd1, 10);
    expect_val("t6_drop_cnt", 2);     check(o_c0_drop_cnt);
    wait_c0(3'd2, 40);
    for (int k = 0; k < 300 && o_c0_state == 3'd2; k++) tick();
    expect_val("t6_retry_cnt", 1);    check(o_c0_retry_cnt);
    wait_c0(3'd2, 40);
    i_enable = 2'b10;
    tick();
    expect_val("t6_idle", 0);         check(o_c0_state);
    expect_val("t6_idle_reset", 1);   check(o_c0_reset);
    expect_val("t6_idle_retry", 0);   check(o_c0_retry_cnt);
    expect_val("t6_idle_drop", 2);    check(o_c0_drop_cnt);

    // 6b. Both channels up, then i_rst
    i_enable = 2'b00;
    tick();
    i_c0_loopback_cfg = 3'd5;
    {i_c0_lane_up, i_c0_channel_up} = 2'b11;
    {i_c1_lane_up, i_c1_channel_up} = 2'b11;
    i_enable = 2'b11;
    wait_c0(3'd3, 100);
    wait_c1(3'd3, 100);
    expect_val("t6_c0_up", 3);        check(o_c0_state);
    expect_val("t6_c1_up", 3);        check(o_c1_state);
    expect_val("t6_c0_lb", 5);        check(o_c0_loopback);
    tick();
    expect_val("t6_all_up", 1);       check(o_all_up);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    expect_val("t6_rst_c0_state", 0); check(o_c0_state);
    expect_val("t6_rst_c1_state", 0); check(o_c1_state);
    expect_val("t6_rst_c0_reset", 1); check(o_c0_reset);
    expect_val("t6_rst_c0_lb", 0);    check(o_c0_loopback);
    expect_val("t6_rst_c0_drop", 0);  check(o_c0_drop_cnt);
    expect_val("t6_rst_c0_link", 0);  check(o_c0_link_ok);
    expect_val("t6_rst_all_up", 0);   check(o_all_up);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
